ctrl_uart_rx: RTL and testbench

Bus-attached UART receiver for the ctrl subsystem, the receive-side counterpart of the ctrl UART transmitter. It deserializes 8N1 frames from `uart_rxd` into a small RX FIFO. It answers the ctrl register bus (cs/we/sel/adr → ack/dat_r) at the RX_DATA (0x10) and UART_STAT (0x14) offsets. It sits beside ctrl_regs and is selected by the ctrl address decoder.

---
 rtl/ctrl_uart_rx_pkg.sv | 29 ++
 rtl/ctrl_uart_fifo.sv | 59 +++++
 rtl/ctrl_uart_rx.sv | 178 +++++++++++++++++
 tb/tb_ctrl_uart_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_uart_rx_pkg.sv
// Shared definitions for the ctrl UART receiver: register offsets, status bits, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ctrl_uart_rx_pkg;

    // Byte offsets within the block
    localparam logic [4:0] CTRL_UART_RX_ADR   = 5'h10;
    localparam logic [4:0] CTRL_UART_STAT_ADR = 5'h14;

    // UART_STAT bit positions
    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_RX_FULL   = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    // Receive FSM encodings
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Word index of a byte address; only adr[4:2] is decoded
    function automatic logic [2:0] word_idx(input logic [4:0] a);
        return a[4:2];
    endfunction

endpackage

// File: rtl/ctrl_uart_fifo.sv
// Small 8-bit synchronous FIFO with first-word-fall-through head output.
// Latency: a pushed byte appears on head the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop occurs in the same cycle.
module ctrl_uart_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    import ctrl_uart_rx_pkg::*;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_DEPTH = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot a full push needs
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally modulo depth; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_uart_rx.sv
// 8N1 UART receiver into a small FIFO, read over the ctrl register bus (RX_DATA / UART_STAT).
// Latency: ack one cycle after cs; stop-bit sample ~2 + BAUD_DIV/2 + 9*BAUD_DIV cycles after start edge.
// Backpressure: none on the line; a byte arriving to a full FIFO is dropped and flags overrun.
module ctrl_uart_rx #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    input  logic        cs,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [4:0]  adr,
    output logic [31:0] dat_r,
    output logic        ack,
    output logic        rx_irq
);
    import ctrl_uart_rx_pkg::*;

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV/2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    sync_q;
    logic          rxd_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic          rx_push, frame_err_set;

    logic          cs_q, acc, rd_acc, rx_pop, stat_rd, overrun_set;
    logic          overrun_q, frame_err_q;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [31:0]   stat_word, rd_mux;
    logic          unused_bus_bits;

    // Byte selects and sub-word address bits carry no meaning here
    assign unused_bus_bits = &{1'b0, sel, adr[1:0]};

    // Two-flop synchronizer, idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], uart_rxd};
    end
    assign rxd_s = sync_q[1];

    // Receive FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    // Next-state: count down to mid-bit, sample, and assemble the byte LSB first
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        armed_d       = armed_q;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!armed_q) begin
                    armed_d = rxd_s;
                end else if (!rxd_s) begin
                    state_d = RX_START;
                    cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_s) begin
                        state_d = RX_DATA;
                        cnt_d   = CNT_FULL;
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rxd_s) begin
                        rx_push = 1'b1;
                    end else begin
                        frame_err_set = 1'b1;
                        armed_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    ctrl_uart_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (shift_q),
        .pop   (rx_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // An access fires only on the first edge of a cs assertion
    assign acc         = cs & ~cs_q;
    assign rd_acc      = acc & ~we;
    assign rx_pop      = rd_acc & (word_idx(adr) == word_idx(CTRL_UART_RX_ADR)) & ~fifo_empty;
    assign stat_rd     = rd_acc & (word_idx(adr) == word_idx(CTRL_UART_STAT_ADR));
    assign overrun_set = rx_push & fifo_full & ~rx_pop;
    assign rx_irq      = ~fifo_empty;

    // Read data mux: status word and FIFO head
    always_comb begin
        stat_word                 = '0;
        stat_word[STAT_RX_VALID]  = ~fifo_empty;
        stat_word[STAT_RX_FULL]   = fifo_full;
        stat_word[STAT_OVERRUN]   = overrun_q;
        stat_word[STAT_FRAME_ERR] = frame_err_q;
        rd_mux = '0;
        if (word_idx(adr) == word_idx(CTRL_UART_RX_ADR)) begin
            if (!fifo_empty) rd_mux = {24'h0, fifo_head};
        end else if (word_idx(adr) == word_idx(CTRL_UART_STAT_ADR)) begin
            rd_mux = stat_word;
        end
    end

    // Bus response and sticky error flags; a new set beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= 1'b0;
            ack         <= 1'b0;
            dat_r       <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_q        <= cs;
            ack         <= acc;
            if (rd_acc) dat_r <= rd_mux;
            overrun_q   <= overrun_set   | (overrun_q   & ~stat_rd);
            frame_err_q <= frame_err_set | (frame_err_q & ~stat_rd);
        end
    end

endmodule

// File: tb/tb_ctrl_uart_rx.sv
module tb_ctrl_uart_rx;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [4:0]  adr = 5'h0;
    logic [31:0] dat_r;
    logic        ack;
    logic        rx_irq;

    always #5 clk = ~clk;

    ctrl_uart_rx #(.BAUD_DIV(BD), .FIFO_AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .cs       (cs),
        .we       (we),
        .sel      (sel),
        .adr      (adr),
        .dat_r    (dat_r),
        .ack      (ack),
        .rx_irq   (rx_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: byte queue plus sticky flags
    logic [7:0] mq[$];
    bit         m_ovr  = 1'b0;
    bit         m_ferr = 1'b0;

    typedef struct {
        int          op;   // 0 send, 1 read, 2 write
        logic [7:0]  val;
        logic [4:0]  a;
        logic [31:0] exp;
        logic        irq;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (BD) @(negedge clk);
    endtask

    // stop_low = number of bit times the stop bit is held low (0 = good frame)
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (stop_low == 0) drive_bit(1'b1);
        else repeat (stop_low) drive_bit(1'b0);
        uart_rxd = 1'b1;
        idle(6);
    endtask

    task automatic model_send(input logic [7:0] b, input int stop_low);
        if (stop_low != 0)       m_ferr = 1'b1;
        else if (mq.size() < 4)  mq.push_back(b);
        else                     m_ovr = 1'b1;
    endtask

    task automatic model_read(input logic [4:0] a, output logic [31:0] e);
        e = 32'h0;
        if (a[4:2] == 3'd4) begin
            if (mq.size() > 0) e = {24'h0, mq.pop_front()};
        end else if (a[4:2] == 3'd5) begin
            e = {28'h0, m_ferr, m_ovr, mq.size() == 4, mq.size() != 0};
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    // Bus access starting at a negedge; cs is held one cycle past ack
    task automatic bus_acc(input logic w, input logic [4:0] a, output logic [31:0] d);
        int n;
        cs = 1'b1; we = w; adr = a; sel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        d = dat_r;
        @(negedge clk);
        check("ack_one_cycle", {31'h0, ack}, 32'h0);
        cs = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [4:0] a, input string name);
        logic [31:0] e, d;
        model_read(a, e);
        bus_acc(1'b0, a, d);
        check(name, d, e);
    endtask

    task automatic do_send(input logic [7:0] b, input int stop_low);
        send_frame(b, stop_low);
        model_send(b, stop_low);
    endtask

    initial begin
        logic [31:0] d, e;
        logic [7:0]  pb;
        int          r;

        // Expected vectors for the basic receive and FIFO-fill scenarios
        vecs[0]  = '{0, 8'hAB, 5'h00, 32'h0,  1'b1};
        vecs[1]  = '{1, 8'h00, 5'h14, 32'h1,  1'b1};
        vecs[2]  = '{1, 8'h00, 5'h10, 32'hAB, 1'b0};
        vecs[3]  = '{1, 8'h00, 5'h14, 32'h0,  1'b0};
        vecs[4]  = '{0, 8'h11, 5'h00, 32'h0,  1'b1};
        vecs[5]  = '{0, 8'h22, 5'h00, 32'h0,  1'b1};
        vecs[6]  = '{0, 8'h33, 5'h00, 32'h0,  1'b1};
        vecs[7]  = '{0, 8'h44, 5'h00, 32'h0,  1'b1};
        vecs[8]  = '{0, 8'h55, 5'h00, 32'h0,  1'b1};
        vecs[9]  = '{2, 8'h00, 5'h10, 32'h0,  1'b1};
        vecs[10] = '{1, 8'h00, 5'h14, 32'h7,  1'b1};
        vecs[11] = '{1, 8'h00, 5'h14, 32'h3,  1'b1};
        vecs[12] = '{1, 8'h00, 5'h10, 32'h11, 1'b1};
        vecs[13] = '{1, 8'h00, 5'h10, 32'h22, 1'b1};
        vecs[14] = '{1, 8'h00, 5'h10, 32'h33, 1'b1};
        vecs[15] = '{1, 8'h00, 5'h10, 32'h44, 1'b0};
        vecs[16] = '{1, 8'h00, 5'h14, 32'h0,  1'b0};
        vecs[17] = '{1, 8'h00, 5'h10, 32'h0,  1'b0};

        // Reset values
        idle(3);
        check("rst_ack",    {31'h0, ack},    32'h0);
        check("rst_dat_r",  dat_r,           32'h0);
        check("rst_rx_irq", {31'h0, rx_irq}, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Empty-state reads
        do_read(5'h14, "t1_stat");
        do_read(5'h10, "t1_rxdata_empty");
        check("t1_irq", {31'h0, rx_irq}, 32'h0);

        // Table-driven receive / fill / overrun / drain
        for (int i = 0; i < 18; i++) begin
            case (vecs[i].op)
                0: do_send(vecs[i].val, 0);
                1: begin
                    model_read(vecs[i].a, e);
                    bus_acc(1'b0, vecs[i].a, d);
                    check($sformatf("vec%0d_dat", i), d, vecs[i].exp);
                end
                default: bus_acc(1'b1, vecs[i].a, d);
            endcase
            check($sformatf("vec%0d_irq", i), {31'h0, rx_irq}, {31'h0, vecs[i].irq});
        end

        // Frame error: stop bit low for two bit times, then a clean frame
        do_send(8'h5A, 2);
        do_read(5'h14, "t4_stat_ferr");
        check("t4_irq", {31'h0, rx_irq}, 32'h0);
        do_send(8'h3C, 0);
        do_read(5'h10, "t4_rx_3c");
        do_read(5'h14, "t4_stat_clean");

        // Short glitch on idle line, then glitch overlapping a status read
        uart_rxd = 1'b0; idle(3); uart_rxd = 1'b1;
        idle(20);
        do_read(5'h14, "t5_glitch_stat");
        check("t5_irq", {31'h0, rx_irq}, 32'h0);
        fork
            begin uart_rxd = 1'b0; idle(3); uart_rxd = 1'b1; end
            do_read(5'h14, "t5_glitch_during_read");
        join
        idle(20);
        do_read(5'h14, "t5_glitch_after");
        do_send(8'h96, 0);
        do_read(5'h10, "t5_rx_after_glitch");

        // Frame error set on the same edge as a status-read clear: set wins
        fork
            send_frame(8'hE1, 1);
            begin idle(78); bus_acc(1'b0, 5'h14, d); end
        join
        check("sticky_preclear", d, 32'h0);
        m_ferr = 1'b1;
        do_read(5'h14, "sticky_set_wins");

        // Push into full FIFO on the same edge as a pop: no overrun
        do_send(8'hA1, 0); do_send(8'hA2, 0); do_send(8'hA3, 0); do_send(8'hA4, 0);
        fork
            send_frame(8'hA5, 0);
            begin idle(78); bus_acc(1'b0, 5'h10, d); end
        join
        model_read(5'h10, e);
        model_send(8'hA5, 0);
        check("pushpop_head", d, e);
        do_read(5'h14, "pushpop_stat");
        for (int i = 0; i < 4; i++) do_read(5'h10, "pushpop_drain");

        // Reset during data bit 4 with one byte queued
        do_send(8'h77, 0);
        pb = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(pb[i]);
        uart_rxd = pb[4];
        idle(4);
        rst_n = 1'b0;
        idle(2);
        check("t6_rst_irq", {31'h0, rx_irq}, 32'h0);
        check("t6_rst_ack", {31'h0, ack},    32'h0);
        check("t6_rst_dat", dat_r,           32'h0);
        uart_rxd = 1'b1;
        idle(1);
        rst_n = 1'b1;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        idle(4);
        do_read(5'h14, "t6_stat");
        do_read(5'h10, "t6_empty");
        do_send(8'hC3, 0);
        do_read(5'h10, "t6_rx_c3");
        do_read(5'h14, "t6_stat_clean");

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_send(8'($urandom), 0);
            end else if (r == 4) begin
                do_send(8'($urandom), 1);
            end else if (r == 5) begin
                bus_acc(1'b1, 5'($urandom_range(0, 31)), d);
            end else if (r < 8) begin
                do_read(5'h10, "rnd_rxdata");
            end else if (r == 8) begin
                do_read(5'h14, "rnd_stat");
            end else begin
                do_read(5'(($urandom_range(0, 5) == 0) ? 5'h04 : 5'h18), "rnd_other");
            end
            check("rnd_irq", {31'h0, rx_irq}, {31'h0, mq.size() != 0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
